// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: adds DIGIT bits per clock, LSB digit first,
// with a valid/ready request side and a valid/ready result side.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry_in,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_s,
  output logic             o_carry_out,
  output logic             o_overflow
);

  localparam int N     = (DIGIT >= 1) ? WIDTH / DIGIT : 1;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  if ((DIGIT < 1) || (WIDTH < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
    $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic [DIGIT:0]   dsum;
  logic             msb_cin;
  logic             last;

  function automatic logic [DIGIT:0] digit_add(input logic [DIGIT-1:0] x,
                                               input logic [DIGIT-1:0] y,
                                               input logic             c);
    digit_add = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, c};
  endfunction

  // Operands shift right each RUN cycle, so the current digit is always the low slice.
  always_comb begin
    dsum    = digit_add(a_q[DIGIT-1:0], b_q[DIGIT-1:0], carry_q);
    msb_cin = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1];
    last    = (idx_q == IDX_W'(N - 1));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      o_ready     <= 1'b1;
      o_valid     <= 1'b0;
      o_s         <= '0;
      o_carry_out <= 1'b0;
      o_overflow  <= 1'b0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            a_q     <= i_a;
            b_q     <= i_sub ? ~i_b : i_b;
            // Subtraction is A + ~B + 1, so the seed is forced to 1.
            carry_q <= i_sub | i_carry_in;
            idx_q   <= '0;
            o_ready <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < N; k++) begin
            if (idx_q == IDX_W'(k)) o_s[k*DIGIT +: DIGIT] <= dsum[DIGIT-1:0];
          end
          carry_q <= dsum[DIGIT];
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          idx_q   <= idx_q + IDX_W'(1);
          if (last) begin
            o_carry_out <= dsum[DIGIT];
            o_overflow  <= msb_cin ^ dsum[DIGIT];
            o_valid     <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid     <= 1'b0;
            o_ready     <= 1'b1;
            o_carry_out <= 1'b0;
            o_overflow  <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for digit_serial_adder: three builds (DIGIT = 4, 1, 16)
// run directed corner cases, backpressure, reset abort and random back-to-back traffic.
module tb_digit_serial_adder;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        v;
    logic [31:0] acc;
  } exp_t;

  logic clk;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string name, input int dg, input logic [31:0] act,
                          input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (DIGIT=%0d): got %0h, expected %0h at %0t", name, dg, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input int dg);
    checks++;
    errors++;
    $display("FAIL %s (DIGIT=%0d): bound expired or no result expected at %0t", name, dg, $time);
  endtask

  function automatic exp_t mk(input logic [15:0] s, input logic c, input logic v);
    exp_t e;
    e.s = s; e.c = c; e.v = v; e.acc = '0;
    return e;
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    exp_t e;
    int ua, ub, sa, sb, r, u;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    if (sub) begin
      u = ua - ub; r = sa - sb; e.c = (ua >= ub);
    end else begin
      u = ua + ub + int'(cin); r = sa + sb + int'(cin); e.c = (u > 65535);
    end
    e.s = u[15:0];
    e.v = (r > 32767) || (r < -32768);
    e.acc = '0;
    return e;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int DG = (gi == 0) ? 4 : ((gi == 1) ? 1 : 16);
    localparam int N  = 16 / DG;

    logic        rst, iv, ordy, irdy, cin, sub, ov, cout, ovf;
    logic [15:0] a, b, s;
    exp_t        q[$];
    exp_t        got;
    int          cyc = 0;
    int          last_acc = 0;
    bit          fin = 1'b0;
    bit          ov_prev = 1'b0;
    bit          prev_hold = 1'b0;

    digit_serial_adder #(.WIDTH(16), .DIGIT(DG)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(iv), .o_ready(ordy),
      .i_a(a), .i_b(b), .i_carry_in(cin), .i_sub(sub),
      .o_valid(ov), .i_ready(irdy), .o_s(s),
      .o_carry_out(cout), .o_overflow(ovf)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
      if (!rst) begin
        check_eq("ready_valid_exclusive", DG, {31'b0, ordy & ov}, 32'd0);
        if (!ov) check_eq("flags_outside_done", DG, {30'b0, cout, ovf}, 32'd0);
        if (ov && !ov_prev) begin
          if (q.size() == 0) fail("valid_without_request", DG);
          else check_eq("latency", DG, cyc - int'(q[0].acc), N);
        end
        if (ov && irdy) begin
          if (q.size() == 0) fail("unexpected_result", DG);
          else begin
            got = q.pop_front();
            check_eq("sum", DG, {16'b0, s}, {16'b0, got.s});
            check_eq("carry_out", DG, {31'b0, cout}, {31'b0, got.c});
            check_eq("overflow", DG, {31'b0, ovf}, {31'b0, got.v});
          end
        end
      end
      ov_prev <= ov;
    end

    task automatic issue(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                         input logic ts, input exp_t e, input bit hold);
      int w = 0;
      do begin @(negedge clk); w++; end while (!ordy && w < 100);
      if (!ordy) begin
        fail("ready_timeout", DG);
        return;
      end
      a = ta; b = tb_; cin = tc; sub = ts; iv = 1'b1;
      @(posedge clk); #1;
      e.acc = cyc;
      q.push_back(e);
      if (hold && prev_hold) check_eq("accept_period", DG, cyc - last_acc, N + 2);
      prev_hold = hold;
      last_acc = cyc;
      if (!hold) iv = 1'b0;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    endtask

    task automatic drain();
      int w = 0;
      while (q.size() != 0 && w < 200) begin @(posedge clk); #1; w++; end
      if (q.size() != 0) begin
        fail("drain_timeout", DG);
        q.delete();
      end
    endtask

    task automatic bp_test();
      int w = 0;
      irdy = 1'b0;
      issue(16'hC000, 16'h8001, 1'b0, 1'b0, mk(16'h4001, 1'b1, 1'b1), 1'b0);
      while (!ov && w < 50) begin @(posedge clk); #1; w++; end
      if (!ov) fail("bp_valid_timeout", DG);
      repeat (3) begin
        iv = 1'b1; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        @(posedge clk); #1;
        check_eq("bp_sum_stable", DG, {16'b0, s}, 32'h4001);
        check_eq("bp_flags_stable", DG, {30'b0, cout, ovf}, 32'd3);
        check_eq("bp_ready_low", DG, {31'b0, ordy}, 32'd0);
        check_eq("bp_valid_high", DG, {31'b0, ov}, 32'd1);
      end
      iv = 1'b0;
      irdy = 1'b1;
      drain();
    endtask

    task automatic reset_test();
      irdy = 1'b0;
      issue(16'h1111, 16'h2222, 1'b0, 1'b0, mk(16'h3333, 1'b0, 1'b0), 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1; iv = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; iv = 1'b0;
      void'(q.pop_back());
      check_eq("abort_ready", DG, {31'b0, ordy}, 32'd1);
      check_eq("abort_valid", DG, {31'b0, ov}, 32'd0);
      check_eq("abort_sum", DG, {16'b0, s}, 32'd0);
      check_eq("abort_flags", DG, {30'b0, cout, ovf}, 32'd0);
      irdy = 1'b1;
      issue(16'hABCD, 16'h1234, 1'b1, 1'b1, mk(16'h9999, 1'b1, 1'b0), 1'b0);
      drain();
    endtask

    initial begin
      logic [15:0] ra, rb;
      logic        rc, rs;
      rst = 1'b1; iv = 1'b0; irdy = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_ready", DG, {31'b0, ordy}, 32'd1);
      check_eq("reset_valid", DG, {31'b0, ov}, 32'd0);
      check_eq("reset_sum", DG, {16'b0, s}, 32'd0);
      check_eq("reset_flags", DG, {30'b0, cout, ovf}, 32'd0);
      rst = 1'b0;

      issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0), 1'b0); drain();
      issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1), 1'b0); drain();
      issue(16'h1234, 16'h4321, 1'b1, 1'b0, mk(16'h5556, 1'b0, 1'b0), 1'b0); drain();
      issue(16'h0005, 16'h0007, 1'b1, 1'b1, mk(16'hFFFE, 1'b0, 1'b0), 1'b0); drain();
      issue(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1), 1'b0); drain();

      bp_test();
      reset_test();

      irdy = 1'b1;
      for (int i = 0; i < 1000; i++) begin
        ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
        if (i % 50 == 0) rb = (i % 100 == 0) ? 16'h8000 : ra;
        issue(ra, rb, rc, rs, model(ra, rb, rc, rs), i != 999);
      end
      drain();
      iv = 1'b0;
      fin = 1'b1;
    end
  end

  initial begin
    int t = 0;
    while (!(g_inst[0].fin && g_inst[1].fin && g_inst[2].fin) && t < 60000) begin
      @(posedge clk);
      t++;
    end
    if (!(g_inst[0].fin && g_inst[1].fin && g_inst[2].fin)) fail("global_timeout", 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
